// File: rtl/led_hc595_driver_pkg.sv
// Shared types and defaults for the 74HC595 LED driver: FSM state encoding,
// default parameter values and a frame-length helper.
package led_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT_LO,
        SHIFT_HI,
        LATCH
    } led_state_e;

    localparam int unsigned DEF_LED_WIDTH = 8;
    localparam int unsigned DEF_CLK_DIV   = 4;

    // LOAD + (low + high half-period) per bit + latch pulse
    function automatic int unsigned frame_cycles(input int unsigned led_width,
                                                 input int unsigned clk_div);
        return 1 + 2 * clk_div * led_width + clk_div;
    endfunction

endpackage

// File: rtl/led_hc595_driver_div_tick.sv
// Divider for the 595 driver: emits a one-cycle tick on every CLK_DIV-th
// enabled cycle; the count clears on reset or whenever enable drops.
module led_div_tick #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int unsigned CW = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/led_hc595_driver.sv
// Serialises led_data into a 74HC595 (ds/shcp/stcp), MSB first, resending on
// every change and once after reset. Define LED_ACTIVE_LOW_EN to shift ~led_data.
module led_hc595_driver
    import led_pkg::*;
#(
    parameter int unsigned LED_WIDTH = DEF_LED_WIDTH,
    parameter int unsigned CLK_DIV   = DEF_CLK_DIV
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [LED_WIDTH-1:0] led_data,
    output logic                 ds,
    output logic                 shcp,
    output logic                 stcp,
    output logic                 busy
);

    localparam int unsigned BW = $clog2(LED_WIDTH + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(LED_WIDTH - 1);

    led_state_e           state_q, state_d;
    logic [LED_WIDTH-1:0] shift_q;
    logic [LED_WIDTH-1:0] shadow_q;
    logic [LED_WIDTH-1:0] load_word;
    logic [BW-1:0]        bit_cnt_q;
    logic                 force_q;
    logic                 ds_q;
    logic                 timer_en;
    logic                 tick;

`ifdef LED_ACTIVE_LOW_EN
    assign load_word = ~led_data;
`else
    assign load_word = led_data;
`endif

    led_div_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_div_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (timer_en),
        .tick (tick)
    );

    always_comb begin
        state_d  = state_q;
        timer_en = 1'b0;
        shcp     = 1'b0;
        stcp     = 1'b0;
        busy     = 1'b1;
        ds       = ds_q;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if ((led_data != shadow_q) || force_q) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                state_d = SHIFT_LO;
            end
            SHIFT_LO: begin
                timer_en = 1'b1;
                ds       = shift_q[LED_WIDTH-1];
                if (tick) begin
                    state_d = SHIFT_HI;
                end
            end
            SHIFT_HI: begin
                // ds comes from ds_q here, so it cannot move while shcp is high
                timer_en = 1'b1;
                shcp     = 1'b1;
                if (tick) begin
                    state_d = (bit_cnt_q == LAST_BIT) ? LATCH : SHIFT_LO;
                end
            end
            LATCH: begin
                timer_en = 1'b1;
                stcp     = 1'b1;
                if (tick) begin
                    state_d = IDLE;
                end
            end
            default: begin
                busy    = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            shadow_q  <= '0;
            bit_cnt_q <= '0;
            force_q   <= 1'b1;
            ds_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            ds_q    <= ds;
            if (state_q == LOAD) begin
                shift_q   <= load_word;
                shadow_q  <= led_data;
                force_q   <= 1'b0;
                bit_cnt_q <= '0;
            end else if ((state_q == SHIFT_HI) && tick) begin
                shift_q   <= shift_q << 1;
                bit_cnt_q <= bit_cnt_q + BW'(1);
            end
        end
    end

endmodule
